// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch PC unit: FSM states,
// the reset NOP encoding, control-flow opcodes and the sequential PC step.
package fetch_pc_unit_pkg;

    typedef enum logic {
        FETCH     = 1'b0,
        JALR_WAIT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int unsigned PC_INCREMENT = 4;

endpackage

// File: rtl/fetch_pc_unit.sv
// IF-stage PC register, fetch request generation and IF/ID latch.
// The branch predictor is a sibling instance; this unit only consumes its outputs.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                size     = 32,
    parameter logic [size-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [size-1:0] redirect_pc,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [size-1:0] instruction,
    input  logic [size-1:0] imm,
    input  logic            predicted_mpc,
    input  logic            jalr,
    output logic            if_valid,
    output logic [size-1:0] if_pc,
    output logic [size-1:0] if_instruction
);

    fetch_state_e    state_q, state_d;
    logic [size-1:0] pc_q, pc_d;
    logic            if_valid_q, if_valid_d;
    logic [size-1:0] if_pc_q, if_pc_d;
    logic [size-1:0] if_instruction_q, if_instruction_d;

    logic            accept;
    logic [size-1:0] pc_seq;
    logic [size-1:0] pc_taken;

    assign imem_req       = (state_q == FETCH);
    assign imem_addr      = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instruction = if_instruction_q;

    assign accept   = (state_q == FETCH) & imem_ready & ~stall & ~redirect_valid;
    assign pc_seq   = pc_q + size'(PC_INCREMENT);
    assign pc_taken = pc_q + imm;

    // Redirect beats everything (including stall); a JALR parks the PC until execute resolves it.
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        if_instruction_d = if_instruction_q;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[size-1:2], 2'b00};
            state_d    = FETCH;
            if_valid_d = 1'b0;
        end else if (stall) begin
            state_d = state_q;
        end else if (accept) begin
            if_valid_d       = 1'b1;
            if_pc_d          = pc_q;
            if_instruction_d = instruction;
            if (jalr) begin
                state_d = JALR_WAIT;
            end else if (predicted_mpc) begin
                pc_d = pc_taken;
            end else begin
                pc_d = pc_seq;
            end
        end else begin
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= FETCH;
            pc_q             <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_q          <= '0;
            if_instruction_q <= size'(NOP_INSTR);
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            if_instruction_q <= if_instruction_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a table of single-cycle vectors followed by
// hand-written stall, redirect, wrap-around and asynchronous-reset sequences.
module tb_fetch_pc_unit;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_ready;
    logic [W-1:0]  instruction;
    logic [W-1:0]  imm;
    logic          predicted_mpc;
    logic          jalr;
    logic          if_valid;
    logic [W-1:0]  if_pc;
    logic [W-1:0]  if_instruction;

    int checks = 0;
    int errors = 0;

    fetch_pc_unit #(
        .size     (W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .instruction    (instruction),
        .imm            (imm),
        .predicted_mpc  (predicted_mpc),
        .jalr           (jalr),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         stall;
        logic         redirect_valid;
        logic [W-1:0] redirect_pc;
        logic         imem_ready;
        logic [W-1:0] instruction;
        logic [W-1:0] imm;
        logic         predicted_mpc;
        logic         jalr;
        logic [W-1:0] exp_addr;
        logic         exp_req;
        logic         exp_valid;
        logic [W-1:0] exp_if_pc;
        logic [W-1:0] exp_if_instr;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rv, input logic [W-1:0] rpc,
                                 input logic rdy, input logic [W-1:0] ins,
                                 input logic [W-1:0] im, input logic pm, input logic jr);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ready     = rdy;
        instruction    = ins;
        imm            = im;
        predicted_mpc  = pm;
        jalr           = jr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [W-1:0] addr, input logic req,
                            input logic vld, input logic [W-1:0] ipc, input logic [W-1:0] iins);
        checkOutput({tag, ".imem_addr"}, imem_addr, addr);
        checkOutput({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, req});
        checkOutput({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, vld});
        checkOutput({tag, ".if_pc"}, if_pc, ipc);
        checkOutput({tag, ".if_instr"}, if_instruction, iins);
    endtask

    localparam logic [W-1:0] I_A   = 32'h0010_0093;
    localparam logic [W-1:0] I_B   = 32'h0020_0113;
    localparam logic [W-1:0] I_C   = 32'h0030_0193;
    localparam logic [W-1:0] I_D   = 32'h0040_0213;
    localparam logic [W-1:0] I_BR  = 32'hFE00_0EE3;
    localparam logic [W-1:0] I_JR  = 32'h0000_80E7;
    localparam logic [W-1:0] I_E   = 32'h0050_0293;
    localparam logic [W-1:0] NOP   = 32'h0000_0013;

    initial begin
        // Expected state is what the outputs show just after the clock edge that consumed the inputs.
        vecs[0]  = '{"seq0",      0, 0, 32'h0,   1, I_A,  32'h0,        0, 0, 32'h04,  1, 1, 32'h00, I_A};
        vecs[1]  = '{"seq4",      0, 0, 32'h0,   1, I_B,  32'h0,        0, 0, 32'h08,  1, 1, 32'h04, I_B};
        vecs[2]  = '{"seq8",      0, 0, 32'h0,   1, I_C,  32'h0,        0, 0, 32'h0C,  1, 1, 32'h08, I_C};
        vecs[3]  = '{"bubble",    0, 0, 32'h0,   0, I_D,  32'h0,        0, 0, 32'h0C,  1, 0, 32'h08, I_C};
        vecs[4]  = '{"seqC",      0, 0, 32'h0,   1, I_D,  32'h0,        0, 0, 32'h10,  1, 1, 32'h0C, I_D};
        vecs[5]  = '{"taken",     0, 0, 32'h0,   1, I_BR, 32'hFFFF_FFF0, 1, 0, 32'h00, 1, 1, 32'h10, I_BR};
        vecs[6]  = '{"redir20",   0, 1, 32'h20,  1, I_A,  32'h0,        0, 0, 32'h20,  1, 0, 32'h10, I_BR};
        vecs[7]  = '{"jalr",      0, 0, 32'h0,   1, I_JR, 32'h40,       1, 1, 32'h20,  0, 1, 32'h20, I_JR};
        vecs[8]  = '{"jwait1",    0, 0, 32'h0,   1, I_A,  32'h0,        0, 0, 32'h20,  0, 0, 32'h20, I_JR};
        vecs[9]  = '{"jwait2",    0, 0, 32'h0,   1, I_A,  32'h0,        0, 0, 32'h20,  0, 0, 32'h20, I_JR};
        vecs[10] = '{"jresolve",  0, 1, 32'h103, 0, I_A,  32'h0,        0, 0, 32'h100, 1, 0, 32'h20, I_JR};
        vecs[11] = '{"seq100",    0, 0, 32'h0,   1, I_E,  32'h0,        0, 0, 32'h104, 1, 1, 32'h100, I_E};

        applyStimulus(0, 0, '0, 0, '0, '0, 0, 0);
        reset = 1'b1;
        #12;
        checkAll("reset", 32'h0, 1'b1, 1'b0, 32'h0, NOP);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].redirect_valid, vecs[i].redirect_pc,
                          vecs[i].imem_ready, vecs[i].instruction, vecs[i].imm,
                          vecs[i].predicted_mpc, vecs[i].jalr);
            tick();
            checkAll(vecs[i].name, vecs[i].exp_addr, vecs[i].exp_req, vecs[i].exp_valid,
                     vecs[i].exp_if_pc, vecs[i].exp_if_instr);
        end

        // Two-cycle stall with a valid instruction held in IF/ID, then resume at 0x40.
        applyStimulus(0, 1, 32'h3C, 0, '0, '0, 0, 0);
        tick();
        applyStimulus(0, 0, '0, 1, I_A, '0, 0, 0);
        tick();
        checkAll("pre_stall", 32'h40, 1'b1, 1'b1, 32'h3C, I_A);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, '0, 1, I_B, '0, 1, 0);
            tick();
            checkAll("stall", 32'h40, 1'b1, 1'b1, 32'h3C, I_A);
        end
        applyStimulus(0, 0, '0, 1, I_B, '0, 0, 0);
        tick();
        checkAll("resume", 32'h44, 1'b1, 1'b1, 32'h40, I_B);

        // Redirect wins over a simultaneous stall and flushes IF/ID.
        applyStimulus(1, 1, 32'h200, 1, I_C, '0, 0, 0);
        tick();
        checkAll("stall_redir", 32'h200, 1'b1, 1'b0, 32'h40, I_B);

        // Not-taken accept at the top of the address space wraps to zero.
        applyStimulus(0, 1, 32'hFFFF_FFFF, 0, '0, '0, 0, 0);
        tick();
        checkOutput("align_redir", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, '0, 1, I_D, '0, 0, 0);
        tick();
        checkAll("wrap", 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, I_D);

        // Enter JALR_WAIT, hold a stall, then assert reset between clock edges.
        applyStimulus(0, 1, 32'h80, 0, '0, '0, 0, 0);
        tick();
        applyStimulus(0, 0, '0, 1, I_JR, '0, 0, 1);
        tick();
        checkAll("jalr80", 32'h80, 1'b0, 1'b1, 32'h80, I_JR);
        applyStimulus(1, 0, '0, 1, I_A, '0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        checkAll("async_rst", 32'h0, 1'b1, 1'b0, 32'h0, NOP);
        #1;
        reset = 1'b0;
        applyStimulus(0, 0, '0, 1, I_E, '0, 0, 0);
        tick();
        checkAll("post_rst", 32'h4, 1'b1, 1'b1, 32'h0, I_E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter size, default 32: width of PC, instruction and immediate.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock; all state rises on posedge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hazard hold from decode.
- redirect_valid  in  1  execute-stage misprediction or JALR resolution.
- redirect_pc  in  size  corrected target.
- imem_req  out  1  fetch request.
- imem_addr  out  size  fetch address (current PC).
- imem_ready  in  1  instruction word valid this cycle.
- instruction  in  size  fetched word; also drives Branch_predictor.instruction.
- imm  in  size  sign-extended branch/JAL offset of instruction.
- predicted_mpc  in  1  Branch_predictor taken prediction.
- jalr  in  1  Branch_predictor JALR flag.
- if_valid  out  1  IF/ID valid; also drives Branch_predictor.isValid.
- if_pc  out  size  PC of the latched instruction.
- if_instruction  out  size  latched instruction.

Function
REQ-004 SHALL implement a two-state FSM: FETCH, JALR_WAIT.
REQ-005 In FETCH, imem_req SHALL be 1; in JALR_WAIT, imem_req SHALL be 0.
REQ-006 imem_addr SHALL equal the PC register, combinationally.
REQ-007 Accept = FETCH & imem_ready & ~stall & ~redirect_valid.
REQ-008 On accept: if_instruction <= instruction, if_pc <= PC, if_valid <= 1.
REQ-009 On accept, next PC SHALL be PC+imm if predicted_mpc, else PC+4; both additions modulo 2^size, no overflow detection.
REQ-010 On accept with jalr=1: PC held; state <= JALR_WAIT. jalr takes priority over predicted_mpc.
REQ-011 JALR_WAIT SHALL persist until redirect_valid; no fetches are issued while in it.
REQ-012 redirect_valid SHALL take priority over all other events, in either state:
- PC <= {redirect_pc[size-1:2], 2'b00};
- state <= FETCH;
- if_valid <= 0 (flush), even when stall=1.
REQ-013 stall=1 without redirect: PC, state, if_valid, if_pc and if_instruction all held.
REQ-014 No accept, no stall, no redirect (imem_ready=0 or JALR_WAIT): PC held; if_valid <= 0 (bubble); if_pc and if_instruction held.
REQ-015 Fetch-to-IF/ID latency SHALL be 1 cycle; back-to-back accepts SHALL sustain one instruction per cycle.
REQ-016 PC = 0xFFFF_FFFC with a not-taken accept SHALL wrap to 0x0000_0000.

Reset
REQ-017 While reset=1, asynchronously:
- PC = RESET_PC;
- state = FETCH;
- if_valid = 0;
- if_pc = 0;
- if_instruction = 32'h0000_0013 (NOP).
REQ-018 Reset asserted mid-JALR_WAIT or mid-stall SHALL discard all pending state.
REQ-019 The first request after reset deassertion SHALL be imem_addr = RESET_PC, on the first clock edge.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enum;
- the NOP constant;
- the opcode constants JAL=1101111, JALR=1100111, BRANCH=1100011;
- the PC increment (4).
REQ-021 No sub-module: next-PC adders and the mux SHALL be inline. Branch_predictor remains a sibling instance in the IF stage wrapper.

Verification
REQ-022 Reset, then imem_ready=1, non-branch words -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; if_valid=1 from cycle 2.
REQ-023 Accept at PC 0x10 with predicted_mpc=1, imm=0xFFFF_FFF0 -> next imem_addr 0x0; if_pc=0x10.
REQ-024 Accept at PC 0x20 with jalr=1 -> imem_req=0 and if_valid=0 from the following cycle; redirect_valid with redirect_pc=0x103 three cycles later -> imem_addr 0x100, FETCH.
REQ-025 stall=1 for 2 cycles at PC 0x40 -> imem_addr, if_pc and if_valid unchanged; resumes at 0x40.
REQ-026 stall=1 and redirect_valid=1 in the same cycle, redirect_pc=0x200 -> imem_addr 0x200 and if_valid=0 next cycle.
REQ-027 PC 0xFFFF_FFFC, not-taken accept -> imem_addr 0x0; reset pulsed asynchronously mid-cycle -> imem_addr=RESET_PC immediately.
